spi_slave_mem_param: RTL
========================

Name: spi_slave_mem_param

Overview:
- Parametrised SPI slave (mode 0, MSB first) fronting an internal register-file memory of 2**ADDR_W words of DATA_W bits.
- Successor to the fixed-width SPI slave memory. Adds configurable widths, wrap-around bursts, invalid-command flagging and clean chip-select abort.
- SPI pins are oversampled in the system clock domain; there is no logic clocked by sclk.
- Sits between an external SPI master (or TB driver) and on-chip configuration/data storage.

Parameters:
- DATA_W, 8: memory word width and SPI data field length in bits.
- ADDR_W, 4: address field length in bits; DEPTH = 2**ADDR_W words.
- SYNC_STAGES, 2: synchroniser depth for cs, sclk and mosi; legal range 2..3.

Ports:
- clk  input  1  system clock; requires f_clk >= 8 x f_sclk.
- rst  input  1  asynchronous, active-high reset.
- cs  input  1  active-low chip select.
- sclk  input  1  SPI serial clock, idles low.
- mosi  input  1  master-out, slave-in data.
- miso  output  1  slave-out data.
- miso_oe  output  1  miso drive enable; high only while cs is low and a read data phase is active.
- busy  output  1  high while a frame is in progress (cs low, state != IDLE).
- cmd_err  output  1  one-clk pulse when an invalid command code completes.
- frame_done  output  1  one-clk pulse when cs rises after a frame with at least one complete data word.

Behaviour:
- Reset values: miso=0, miso_oe=0, busy=0, cmd_err=0, frame_done=0, state=IDLE, shift regs=0, synchronisers=idle (cs=1, sclk=0). Memory contents are not reset.
- Edge detect: sclk rise/fall is detected on the synchronised signal, so internal latency is SYNC_STAGES+1 clk from the pin. Each sclk phase must last >= 4 clk.
- Frame format: 3-bit command, then ADDR_W-bit address, then DATA_W-bit data word(s). All fields are MSB first. Bits are sampled on sclk rise.
- Command codes:
  - 001 SINGLE_WRITE
  - 010 SINGLE_READ
  - 011 BURST_WRITE
  - 100 BURST_READ
  - 000, 101, 110, 111 are invalid.
- States: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - IDLE -> CMD on cs fall.
  - CMD -> ADDR after the 3rd bit, for a valid command.
  - CMD -> IGNORE after the 3rd bit, for an invalid command; cmd_err pulses in the clk after that 3rd bit is sampled.
  - ADDR -> WDATA or RDATA after the ADDR_W-th bit.
  - WDATA/RDATA: single commands go to IGNORE after one word; burst commands stay in place.
  - Any state -> IDLE on cs rise.
- Write: mem[addr] is updated 1 clk after the rising sclk edge that samples the DATA_W-th bit. For bursts, addr then increments modulo DEPTH (DEPTH-1 wraps to 0).
- Read: mem[addr] is loaded into the tx shift register on the clk after the last address bit.
  - The MSB is driven on the following sclk fall; subsequent bits are driven on each later fall.
  - Bursts prefetch mem[addr+1 mod DEPTH] when the current word's LSB is driven.
  - A single read drives 0 with miso_oe=0 after its word.
- Read-during-write to the same address cannot occur, because both phases never run in one frame.
- cs rises mid-field: the frame is aborted and the partial write word is discarded with no memory update. miso=0 and miso_oe=0 within 1 clk of synchronised cs rise. The next frame starts clean in CMD.
- cs rise coinciding with an sclk edge (same synchronised clk): cs takes priority and the sclk edge is ignored.
- Words already committed before the abort remain written.
- cs held low with no sclk: state holds indefinitely.
- IGNORE: all sclk edges are discarded, miso=0, miso_oe=0 until cs rises.
- rst asserted mid-frame: immediate return to reset values with no memory update in progress. After rst deasserts, the block waits for a cs fall.
- frame_done pulses 1 clk after synchronised cs rise, only if >= 1 full data word was written or read.

Test Plan:
- Single write/read: SINGLE_WRITE addr 0x3 data 0xA5, then SINGLE_READ addr 0x3 -> miso shifts 10100101, frame_done pulses once per frame.
- Burst wrap: BURST_WRITE addr 0xE with 0x11,0x22,0x33,0x44, then BURST_READ addr 0xE for 4 words -> reads 0x11,0x22,0x33,0x44, confirming mem[0x0]=0x33 and mem[0x1]=0x44.
- Invalid command: send 110 followed by 12 clocked bits -> cmd_err single pulse, miso_oe stays 0. A subsequent SINGLE_READ of addr 0x3 still returns 0xA5.
- CS abort: SINGLE_WRITE addr 0x5 data 0xFF, raise cs after 4 data bits -> no write, so SINGLE_READ 0x5 returns its prior value (write 0x00 first). A new frame immediately after decodes correctly.
- Mid-frame reset: assert rst during a BURST_READ data phase -> miso=0, miso_oe=0, busy=0 within 1 clk. After release, SINGLE_READ works.
- Random: 200 randomised single/burst frames (random addr, data, burst length 1..20, 10% early cs release) checked against a reference memory model.

Source files
------------

// File: rtl/spi_slave_mem_param.sv
// Mode-0 SPI slave fronting a 2**ADDR_W x DATA_W register file.
// All SPI pins are oversampled in the clk domain; nothing is clocked by sclk.
module spi_slave_mem_param #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic sclk,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic busy,
    output logic cmd_err,
    output logic frame_done
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int MAXF_A = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int MAXF   = (MAXF_A > 3) ? MAXF_A : 3;
    localparam int CNT_W  = $clog2(MAXF + 1);

    localparam logic [2:0] CMD_SW = 3'b001;
    localparam logic [2:0] CMD_SR = 3'b010;
    localparam logic [2:0] CMD_BW = 3'b011;
    localparam logic [2:0] CMD_BR = 3'b100;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [2:0]             cmd_q, cmd_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      tx_q, tx_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   word_seen_q, word_seen_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   busy_q, busy_d;
    logic                   cmd_err_q, cmd_err_d;
    logic                   frame_done_q, frame_done_d;

    logic [DATA_W-1:0]      mem_q [DEPTH];

    logic                   cs_s, sclk_s, mosi_s;
    logic                   cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic                   is_burst, is_write, wr_en;
    logic [2:0]             cmd_shift;
    logic [ADDR_W-1:0]      addr_shift, addr_inc;
    logic [DATA_W-1:0]      data_shift;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    assign cmd_shift  = {cmd_q[1:0], mosi_s};
    assign addr_shift = (addr_q << 1) | ADDR_W'(mosi_s);
    assign data_shift = (wdata_q << 1) | DATA_W'(mosi_s);
    assign addr_inc   = addr_q + ADDR_W'(1);
    assign is_burst   = (cmd_q == CMD_BW) || (cmd_q == CMD_BR);
    assign is_write   = (cmd_q == CMD_SW) || (cmd_q == CMD_BW);

    always_comb begin
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs};
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        cs_prev_d    = cs_s;
        sclk_prev_d  = sclk_s;
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        tx_d         = tx_q;
        bit_cnt_d    = bit_cnt_q;
        word_seen_d  = word_seen_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        cmd_err_d    = 1'b0;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;

        // A cs rise wins over any sclk edge seen in the same cycle.
        if (cs_rise) begin
            state_d      = IDLE;
            miso_d       = 1'b0;
            miso_oe_d    = 1'b0;
            frame_done_d = word_seen_q;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d     = CMD;
                        cmd_d       = '0;
                        addr_d      = '0;
                        wdata_d     = '0;
                        tx_d        = '0;
                        bit_cnt_d   = '0;
                        word_seen_d = 1'b0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_d     = cmd_shift;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(2)) begin
                            bit_cnt_d = '0;
                            if (cmd_shift inside {CMD_SW, CMD_SR, CMD_BW, CMD_BR}) begin
                                state_d = ADDR;
                            end else begin
                                state_d   = IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        addr_d    = addr_shift;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                            bit_cnt_d = '0;
                            if (is_write) begin
                                state_d = WDATA;
                            end else begin
                                state_d = RDATA;
                                tx_d    = mem_q[addr_shift];
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        wdata_d   = data_shift;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            wr_en       = 1'b1;
                            word_seen_d = 1'b1;
                            bit_cnt_d   = '0;
                            if (is_burst) begin
                                addr_d = addr_inc;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                RDATA: begin
                    // Falls drive bits; the LSB fall of a burst also prefetches the next word.
                    if (sclk_fall) begin
                        miso_d    = tx_q[DATA_W-1];
                        miso_oe_d = 1'b1;
                        tx_d      = tx_q << 1;
                        if (is_burst && (bit_cnt_q == CNT_W'(DATA_W - 1))) begin
                            tx_d   = mem_q[addr_inc];
                            addr_d = addr_inc;
                        end
                    end else if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_d   = '0;
                            word_seen_d = 1'b1;
                            if (!is_burst) begin
                                state_d   = IGNORE;
                                miso_d    = 1'b0;
                                miso_oe_d = 1'b0;
                            end
                        end
                    end
                end
                IGNORE: begin
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_q    <= '1;
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            cs_prev_q    <= 1'b1;
            sclk_prev_q  <= 1'b0;
            state_q      <= IDLE;
            cmd_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            tx_q         <= '0;
            bit_cnt_q    <= '0;
            word_seen_q  <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cs_sync_q    <= cs_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            cs_prev_q    <= cs_prev_d;
            sclk_prev_q  <= sclk_prev_d;
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            tx_q         <= tx_d;
            bit_cnt_q    <= bit_cnt_d;
            word_seen_q  <= word_seen_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            busy_q       <= busy_d;
            cmd_err_q    <= cmd_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage is deliberately not reset; wr_en is already gated by the reset state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr_q] <= data_shift;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign busy       = busy_q;
    assign cmd_err    = cmd_err_q;
    assign frame_done = frame_done_q;
endmodule
